// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between execute and load results, registered
// write-back stage, load-pending scoreboard with hazard detect. Optional bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int Width = 32,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic [AW-1:0]    ex_rd_i,
  input  logic [Width-1:0] ex_data_i,
  output logic             ex_ready_o,
  input  logic             ld_valid_i,
  input  logic [AW-1:0]    ld_rd_i,
  input  logic [Width-1:0] ld_data_i,
  output logic             ld_ready_o,
  input  logic             alloc_valid_i,
  input  logic [AW-1:0]    alloc_rd_i,
  output logic             alloc_ready_o,
  input  logic [AW-1:0]    ra_i,
  input  logic [AW-1:0]    rb_i,
  output logic             hazard_o,
  output logic             wen_o,
  output logic [AW-1:0]    rw_o,
  output logic [Width-1:0] busw_o,
  output logic             byp_a_o,
  output logic             byp_b_o,
  output logic [Width-1:0] byp_data_o
);
  localparam int NREG = 1 << AW;
  localparam logic SIDE_EX = 1'b0;
  localparam logic SIDE_LD = 1'b1;

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [Width-1:0] data;
  } wb_req_t;

  logic            rr;
  logic [NREG-1:0] pending;
  logic            gnt_ex, gnt_ld, gnt_any;
  wb_req_t         gnt_req;
  logic [NREG-1:0] set_mask, clr_mask;

  always_comb begin
    gnt_ld   = ld_valid_i & (~ex_valid_i | (rr == SIDE_LD));
    gnt_ex   = ex_valid_i & ~gnt_ld;
    gnt_any  = gnt_ld | gnt_ex;
    gnt_req  = gnt_ld ? '{rd: ld_rd_i, data: ld_data_i} : '{rd: ex_rd_i, data: ex_data_i};
    set_mask = '0;
    clr_mask = '0;
    if (alloc_valid_i && alloc_ready_o && alloc_rd_i != '0) set_mask[alloc_rd_i] = 1'b1;
    if (gnt_ld) clr_mask[ld_rd_i] = 1'b1;
  end

  assign ex_ready_o    = gnt_ex;
  assign ld_ready_o    = gnt_ld;
  assign alloc_ready_o = ~pending[alloc_rd_i];
  assign hazard_o      = ((ra_i != '0) & pending[ra_i]) | ((rb_i != '0) & pending[rb_i]);

  // Clear wins over set; the alloc_ready handshake already keeps them on different registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr      <= SIDE_LD;
      pending <= '0;
      wen_o   <= 1'b0;
      rw_o    <= '0;
      busw_o  <= '0;
    end else begin
      if (ex_valid_i && ld_valid_i) rr <= ~rr;
      pending <= (pending | set_mask) & ~clr_mask;
      wen_o   <= gnt_any & (gnt_req.rd != '0);
      if (gnt_any) begin
        rw_o   <= gnt_req.rd;
        busw_o <= gnt_req.data;
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_a_o    = wen_o & (rw_o == ra_i) & (ra_i != '0);
  assign byp_b_o    = wen_o & (rw_o == rb_i) & (rb_i != '0);
  assign byp_data_o = busw_o;
`else
  assign byp_a_o    = 1'b0;
  assign byp_b_o    = 1'b0;
  assign byp_data_o = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural arbiter/scoreboard model.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ld_valid, alloc_valid;
  logic [4:0]  ex_rd, ld_rd, alloc_rd, ra, rb;
  logic [31:0] ex_data, ld_data;
  logic        ex_ready, ld_ready, alloc_ready, hazard, wen, byp_a, byp_b;
  logic [4:0]  rw;
  logic [31:0] busw, byp_data;
  int n_checks = 0;
  int n_fail   = 0;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.Width(32), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_data_i(ex_data), .ex_ready_o(ex_ready),
    .ld_valid_i(ld_valid), .ld_rd_i(ld_rd), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd), .alloc_ready_o(alloc_ready),
    .ra_i(ra), .rb_i(rb), .hazard_o(hazard),
    .wen_o(wen), .rw_o(rw), .busw_o(busw),
    .byp_a_o(byp_a), .byp_b_o(byp_b), .byp_data_o(byp_data)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    alloc_valid = 0; alloc_rd = 0; ra = 0; rb = 0;
  endtask

  task automatic do_reset;
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    ra = 7; rb = 9; #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", wen); end
    n_checks++; if (rw !== 5'd0 || busw !== 32'd0) begin n_fail++; $display("FAIL reset_rw_busw got=%0d/%h exp=0/0", rw, busw); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    alloc_valid = 1; alloc_rd = 9; tick();
    alloc_valid = 0; ex_valid = 1; ex_rd = 4; ex_data = 32'h1234; tick();
    ex_valid = 0; ra = 9; #1;
    n_checks++; if (wen !== 1'b1 || hazard !== 1'b1) begin n_fail++; $display("FAIL prereset_state got wen=%b hz=%b exp=1/1", wen, hazard); end
    rst = 1; #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL async_reset_wen got=%b exp=0", wen); end
    n_checks++; if (hazard !== 1'b0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_pending got hz=%b ardy=%b exp=0/1", hazard, alloc_ready); end
    n_checks++; if (rw !== 5'd0 || busw !== 32'd0) begin n_fail++; $display("FAIL async_reset_rw got=%0d/%h exp=0/0", rw, busw); end
    #1 rst = 0; idle(); tick();
  endtask

  task automatic test_single_ex;
    do_reset();
    ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF; #1;
    n_checks++; if (ex_ready !== 1'b1 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL single_ex_ready got ex=%b ld=%b exp=1/0", ex_ready, ld_ready); end
    tick(); ex_valid = 0;
    n_checks++; if (wen !== 1'b1 || rw !== 5'd5 || busw !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_ex_wb got=%b/%0d/%h exp=1/5/deadbeef", wen, rw, busw); end
    tick();
    n_checks++; if (wen !== 1'b0 || rw !== 5'd5 || busw !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/5/deadbeef", wen, rw, busw); end
  endtask

  task automatic test_contention;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bit exp_ld;
      exp_ld = (i % 2 == 0);
      ex_valid = 1; ex_rd = 11; ex_data = 32'hE0 + i;
      ld_valid = 1; ld_rd = 12; ld_data = 32'hA0 + i; #1;
      n_checks++; if (ld_ready !== exp_ld || ex_ready !== !exp_ld) begin n_fail++; $display("FAIL contention_grant[%0d] got ld=%b ex=%b exp ld=%b", i, ld_ready, ex_ready, exp_ld); end
      tick();
      n_checks++;
      if (rw !== (exp_ld ? 5'd12 : 5'd11) || busw !== (exp_ld ? 32'hA0 + i : 32'hE0 + i)) begin
        n_fail++; $display("FAIL contention_wb[%0d] got=%0d/%h", i, rw, busw);
      end
    end
    idle(); tick();
  endtask

  task automatic test_scoreboard;
    do_reset();
    alloc_valid = 1; alloc_rd = 7; #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL alloc7_ready got=%b exp=1", alloc_ready); end
    tick(); alloc_valid = 0; ra = 7; #1;
    n_checks++; if (alloc_ready !== 1'b0 || hazard !== 1'b1) begin n_fail++; $display("FAIL pending7 got ardy=%b hz=%b exp=0/1", alloc_ready, hazard); end
    ra = 0; rb = 7; #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_rb got=%b exp=1", hazard); end
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77; #1;
    n_checks++; if (ld_ready !== 1'b1 || hazard !== 1'b1) begin n_fail++; $display("FAIL ld7_grant got rdy=%b hz=%b exp=1/1", ld_ready, hazard); end
    tick(); ld_valid = 0;
    n_checks++; if (hazard !== 1'b0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL ld7_clear got hz=%b ardy=%b exp=0/1", hazard, alloc_ready); end
    n_checks++; if (wen !== 1'b1 || rw !== 5'd7 || busw !== 32'h77) begin n_fail++; $display("FAIL ld7_wb got=%b/%0d/%h exp=1/7/77", wen, rw, busw); end
    alloc_valid = 1; alloc_rd = 8; tick();
    alloc_valid = 0; ex_valid = 1; ex_rd = 8; ex_data = 32'h88; ra = 8; tick();
    ex_valid = 0; #1;
    n_checks++; if (hazard !== 1'b1 || wen !== 1'b1 || rw !== 5'd8) begin n_fail++; $display("FAIL ex_to_pending got hz=%b wen=%b rw=%0d exp=1/1/8", hazard, wen, rw); end
    idle(); tick();
  endtask

  task automatic test_x0;
    do_reset();
    ex_valid = 1; ex_rd = 0; ex_data = 32'h1; #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", ex_ready); end
    tick(); ex_valid = 0;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen got=%b exp=0", wen); end
    alloc_valid = 1; alloc_rd = 0; #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL alloc0_ready got=%b exp=1", alloc_ready); end
    tick(); alloc_valid = 0; ra = 0; rb = 0; #1;
    n_checks++; if (hazard !== 1'b0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL alloc0_state got hz=%b ardy=%b exp=0/1", hazard, alloc_ready); end
  endtask

  task automatic test_bypass;
    do_reset();
    ex_valid = 1; ex_rd = 3; ex_data = 32'h55; tick();
    ex_valid = 0; ra = 3; rb = 3; #1;
    n_checks++; if (wen !== 1'b1 || rw !== 5'd3 || busw !== 32'h55) begin n_fail++; $display("FAIL byp_setup got=%b/%0d/%h exp=1/3/55", wen, rw, busw); end
    n_checks++; if (byp_a !== BYP || byp_b !== BYP) begin n_fail++; $display("FAIL byp_hit got a=%b b=%b exp=%b", byp_a, byp_b, BYP); end
    n_checks++; if (byp_data !== (BYP ? 32'h55 : 32'h0)) begin n_fail++; $display("FAIL byp_data got=%h exp=%h", byp_data, BYP ? 32'h55 : 32'h0); end
    rb = 4; #1;
    n_checks++; if (byp_b !== 1'b0) begin n_fail++; $display("FAIL byp_miss got=%b exp=0", byp_b); end
    idle(); tick();
  endtask

  task automatic test_random;
    bit          pend[32];
    bit          pref_ld;
    bit          e_wen, e_exr, e_ldr, e_ardy, e_hz, win_ld, e_ba, e_bb;
    logic [4:0]  e_rw, g_rd;
    logic [31:0] e_busw, g_data;
    do_reset();
    foreach (pend[i]) pend[i] = 0;
    pref_ld = 1; e_wen = 0; e_rw = 0; e_busw = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ex_valid && $urandom_range(0, 2) != 0) begin
        ex_valid = 1; ex_rd = 5'($urandom_range(0, 7)); ex_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 2) != 0) begin
        ld_valid = 1; ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
      end
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_rd = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      #1;
      e_ardy = !pend[alloc_rd];
      e_hz   = (ra != 0 && pend[ra]) || (rb != 0 && pend[rb]);
      win_ld = (ex_valid && ld_valid) ? pref_ld : ld_valid;
      e_ldr  = ld_valid && win_ld;
      e_exr  = ex_valid && !e_ldr;
      e_ba   = BYP && e_wen && e_rw == ra && ra != 0;
      e_bb   = BYP && e_wen && e_rw == rb && rb != 0;
      n_checks++; if (ex_ready !== e_exr || ld_ready !== e_ldr) begin n_fail++; $display("FAIL rnd_grant[%0d] got ex=%b ld=%b exp ex=%b ld=%b", c, ex_ready, ld_ready, e_exr, e_ldr); end
      n_checks++; if (alloc_ready !== e_ardy) begin n_fail++; $display("FAIL rnd_alloc_ready[%0d] got=%b exp=%b", c, alloc_ready, e_ardy); end
      n_checks++; if (hazard !== e_hz) begin n_fail++; $display("FAIL rnd_hazard[%0d] got=%b exp=%b", c, hazard, e_hz); end
      n_checks++; if (byp_a !== e_ba || byp_b !== e_bb) begin n_fail++; $display("FAIL rnd_bypass[%0d] got a=%b b=%b exp a=%b b=%b", c, byp_a, byp_b, e_ba, e_bb); end
      if (ex_valid && ld_valid) pref_ld = !win_ld;
      g_rd   = e_ldr ? ld_rd : ex_rd;
      g_data = e_ldr ? ld_data : ex_data;
      e_wen  = (e_exr || e_ldr) && g_rd != 0;
      if (e_exr || e_ldr) begin e_rw = g_rd; e_busw = g_data; end
      if (alloc_valid && e_ardy && alloc_rd != 0) pend[alloc_rd] = 1;
      if (e_ldr) pend[ld_rd] = 0;
      tick();
      n_checks++; if (wen !== e_wen) begin n_fail++; $display("FAIL rnd_wen[%0d] got=%b exp=%b", c, wen, e_wen); end
      if (e_wen) begin
        n_checks++; if (rw !== e_rw || busw !== e_busw) begin n_fail++; $display("FAIL rnd_wb[%0d] got=%0d/%h exp=%0d/%h", c, rw, busw, e_rw, e_busw); end
      end
      if (e_exr) ex_valid = 0;
      if (e_ldr) ld_valid = 0;
    end
    idle(); tick();
  endtask

  initial begin
    rst = 1; idle();
    test_reset();
    test_single_ex();
    test_contention();
    test_scoreboard();
    test_x0();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
